dram_burst_streamer: RTL and testbench

Parametrised successor to the single-word DRAM/SD bridge. It reads a burst of 1 to 2^LEN_W words from DRAM over the AXI read channels. In copy mode it also writes each word back to a destination DRAM address over the AXI write channels. Every word is then streamed MSB-first on `out_data`, OUT_W bits per cycle. The block sits between the command source and the pseudo-DRAM AXI slave, and replaces the fixed 64-bit/8-beat, single-address transfer path.

---
 rtl/dram_burst_streamer.sv | 183 ++++++++++++++++++
 tb/tb_dram_burst_streamer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_streamer.sv
// dram_burst_streamer: reads a burst of len+1 DRAM words over AXI, in copy mode
// writes each word back to a destination address, and streams every word
// MSB-first in OUT_W-bit beats. All outputs come straight from flops.
module dram_burst_streamer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64,
  parameter int OUT_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr_src,
  input  logic [ADDR_W-1:0] addr_dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              AR_VALID,
  input  logic              AR_READY,
  output logic [31:0]       AR_ADDR,
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [31:0]       AW_ADDR,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_RESP
);
  localparam int BEATS = DATA_W / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, STREAM, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              eflag_q, eflag_d;

  // Word addresses wrap inside ADDR_W before zero-extension to the bus.
  logic [ADDR_W-1:0] rd_word, wr_word;
  assign rd_word = src_d + ADDR_W'(idx_d);
  assign wr_word = dst_d + ADDR_W'(idx_d);

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    beat_d  = '0;
    buf_d   = buf_q;
    eflag_d = eflag_q;
    case (state_q)
      IDLE: if (in_valid) begin
        mode_d  = mode;
        src_d   = addr_src;
        dst_d   = addr_dst;
        len_d   = len;
        idx_d   = '0;
        state_d = RD_ADDR;
      end
      RD_ADDR: if (AR_VALID && AR_READY) state_d = RD_DATA;
      RD_DATA: if (R_VALID && R_READY) begin
        buf_d = R_DATA;
        if (R_RESP != 2'b00) begin
          eflag_d = 1'b1;
          state_d = FINISH;
        end else if (mode_q) begin
          state_d = WR_ADDR;
        end else begin
          state_d = STREAM;
        end
      end
      WR_ADDR: if (AW_VALID && AW_READY) state_d = WR_DATA;
      WR_DATA: if (W_VALID && W_READY) state_d = WR_RESP;
      WR_RESP: if (B_VALID && B_READY) begin
        if (B_RESP != 2'b00) begin
          eflag_d = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (beat_q == LAST_BEAT) begin
          if (idx_q == len_q) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = RD_ADDR;
          end
        end else begin
          // Shift so the next beat always sits in the top OUT_W bits.
          beat_d = beat_q + BW'(1);
          buf_d  = buf_q << OUT_W;
        end
      end
      FINISH: begin
        eflag_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and burst context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      buf_q   <= '0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      eflag_q <= eflag_d;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they belong to; address/data fields are zero
  // outside their own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AR_VALID  <= 1'b0;
      AR_ADDR   <= '0;
      R_READY   <= 1'b0;
      AW_VALID  <= 1'b0;
      AW_ADDR   <= '0;
      W_VALID   <= 1'b0;
      W_DATA    <= '0;
      B_READY   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      AR_VALID  <= (state_d == RD_ADDR);
      AR_ADDR   <= (state_d == RD_ADDR) ? 32'(rd_word) : '0;
      R_READY   <= (state_d == RD_DATA);
      AW_VALID  <= (state_d == WR_ADDR);
      AW_ADDR   <= (state_d == WR_ADDR) ? 32'(wr_word) : '0;
      W_VALID   <= (state_d == WR_DATA);
      W_DATA    <= (state_d == WR_DATA) ? buf_d : '0;
      B_READY   <= (state_d == WR_RESP);
      out_valid <= (state_d == STREAM);
      out_data  <= (state_d == STREAM) ? buf_d[DATA_W-1 -: OUT_W] : '0;
      busy      <= (state_d != IDLE);
      done      <= (state_d == FINISH);
      err       <= (state_d == FINISH) && eflag_d;
    end
  end
endmodule

// File: tb/tb_dram_burst_streamer.sv
// Directed bench for dram_burst_streamer: 64/8 instance with a behavioural
// AXI slave (optional random stalls, error injection), plus a 32/16 instance.
module tb_dram_burst_streamer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (default parameters) ----------------
  logic        in_valid = 1'b0, mode = 1'b0;
  logic [12:0] addr_src = '0, addr_dst = '0;
  logic [3:0]  len = '0;
  logic        busy, done, err, out_valid;
  logic [7:0]  out_data;
  logic        AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY;
  logic        W_VALID, W_READY, B_VALID, B_READY;
  logic [31:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA;
  logic [1:0]  R_RESP, B_RESP;

  dram_burst_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .addr_src(addr_src), .addr_dst(addr_dst), .len(len),
    .busy(busy), .done(done), .err(err), .out_valid(out_valid), .out_data(out_data),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP)
  );

  // Source memory content, a fixed function of the word address.
  function automatic logic [63:0] memval(input logic [31:0] a);
    if (a == 32'd5) return 64'h0123_4567_89AB_CDEF;
    return {16'hC0DE, a[15:0], ~a[15:0], 16'h3C00 ^ a[15:0]};
  endfunction

  logic        dly_en = 1'b0, w_hold = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        rd_pend, wr_pend;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] wmem [0:255];
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, ovl = 0, zviol = 0;
  logic [31:0] ar_log [$];
  logic [7:0]  beats [$];

  // AXI slave: random per-cycle READY/VALID gating when dly_en is set.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      AR_READY <= 1'b0; R_VALID <= 1'b0; R_DATA <= '0; R_RESP <= 2'b00;
      AW_READY <= 1'b0; W_READY <= 1'b0; B_VALID <= 1'b0; B_RESP <= 2'b00;
      rd_pend <= 1'b0; wr_pend <= 1'b0; rd_addr <= '0; wr_addr <= '0;
    end else begin
      AR_READY <= dly_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      AW_READY <= dly_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      W_READY  <= w_hold ? 1'b0 : (dly_en ? ($urandom_range(0, 2) == 0) : 1'b1);
      if (AR_VALID && AR_READY) begin
        rd_pend <= 1'b1; rd_addr <= AR_ADDR; ar_cnt <= ar_cnt + 1; ar_log.push_back(AR_ADDR);
      end
      if (R_VALID && R_READY) R_VALID <= 1'b0;
      else if (rd_pend && !R_VALID && (!dly_en || $urandom_range(0, 1) == 0)) begin
        R_VALID <= 1'b1; R_DATA <= memval(rd_addr);
        R_RESP <= (rd_addr == err_addr) ? 2'b10 : 2'b00; rd_pend <= 1'b0;
      end
      if (AW_VALID && AW_READY) begin wr_addr <= AW_ADDR; aw_cnt <= aw_cnt + 1; end
      if (W_VALID && W_READY) begin
        wmem[wr_addr[7:0]] <= W_DATA; w_cnt <= w_cnt + 1; wr_pend <= 1'b1;
      end
      if (B_VALID && B_READY) B_VALID <= 1'b0;
      else if (wr_pend && !B_VALID && (!dly_en || $urandom_range(0, 1) == 0)) begin
        B_VALID <= 1'b1; B_RESP <= 2'b00; wr_pend <= 1'b0;
      end
      if (AW_VALID && W_VALID) ovl <= ovl + 1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid) beats.push_back(out_data);
    else if (out_data != 8'h00) zviol <= zviol + 1;
  end

  // ---------------- DUT 2 (32-bit words, 16-bit beats) ----------------
  logic        in_valid2 = 1'b0, mode2 = 1'b0;
  logic [12:0] src2 = '0, dst2 = '0;
  logic [3:0]  len2 = '0;
  logic        busy2, done2, err2, out_valid2;
  logic [15:0] out_data2;
  logic        AR_VALID2, R_VALID2, R_READY2, AW_VALID2, W_VALID2, B_READY2;
  logic [31:0] AR_ADDR2, AW_ADDR2, R_DATA2, W_DATA2;
  logic        AR_READY2 = 1'b1, AW_READY2 = 1'b1, W_READY2 = 1'b1, B_VALID2 = 1'b0;
  logic [1:0]  R_RESP2 = 2'b00, B_RESP2 = 2'b00;
  logic        rd_pend2;
  logic [31:0] rd_addr2;
  int          ar_cnt2 = 0;
  logic [15:0] beats2 [$];

  dram_burst_streamer #(.ADDR_W(13), .DATA_W(32), .OUT_W(16), .LEN_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .mode(mode2),
    .addr_src(src2), .addr_dst(dst2), .len(len2),
    .busy(busy2), .done(done2), .err(err2), .out_valid(out_valid2), .out_data(out_data2),
    .AR_VALID(AR_VALID2), .AR_READY(AR_READY2), .AR_ADDR(AR_ADDR2),
    .R_VALID(R_VALID2), .R_READY(R_READY2), .R_DATA(R_DATA2), .R_RESP(R_RESP2),
    .AW_VALID(AW_VALID2), .AW_READY(AW_READY2), .AW_ADDR(AW_ADDR2),
    .W_VALID(W_VALID2), .W_READY(W_READY2), .W_DATA(W_DATA2),
    .B_VALID(B_VALID2), .B_READY(B_READY2), .B_RESP(B_RESP2)
  );

  // Read-only slave for DUT 2: word = {a ^ 5A5A, a + 1111} (16-bit halves).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      R_VALID2 <= 1'b0; R_DATA2 <= '0; rd_pend2 <= 1'b0; rd_addr2 <= '0;
    end else begin
      if (AR_VALID2 && AR_READY2) begin rd_pend2 <= 1'b1; rd_addr2 <= AR_ADDR2; ar_cnt2 <= ar_cnt2 + 1; end
      if (R_VALID2 && R_READY2) R_VALID2 <= 1'b0;
      else if (rd_pend2 && !R_VALID2) begin
        R_VALID2 <= 1'b1; R_DATA2 <= {rd_addr2[15:0] ^ 16'h5A5A, rd_addr2[15:0] + 16'h1111};
        rd_pend2 <= 1'b0;
      end
    end
  end

  always @(negedge clk) if (out_valid2) beats2.push_back(out_data2);

  // ---------------- checking helpers ----------------
  int   ncmp = 0, nerr = 0;
  logic got_err, got_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic m, input logic [12:0] s, input logic [12:0] d, input logic [3:0] l);
    @(negedge clk);
    mode = m; addr_src = s; addr_dst = d; len = l; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_done"}, done, 1);
    got_err = err; got_busy = busy;
  endtask

  task automatic chk_word(input string tag, input int base, input logic [63:0] w);
    logic [63:0] t;
    for (int k = 0; k < 8; k++) begin
      t = w << (8 * k);
      chk($sformatf("%s_b%0d", tag, k), beats[base+k], t[63:56]);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0]  exp1 [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [15:0] exp6 [4] = '{16'h5A72, 16'h1139, 16'h5A73, 16'h113A};
  int nb, na, naw, nw, n;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, busy, done, err, out_valid}, 0);
    chk("rst_addr", {AR_ADDR, AW_ADDR}, 0);
    chk("rst_data", {W_DATA, out_data}, 0);
    rst = 1'b0;

    // T1: stream one word from address 5.
    nb = beats.size();
    cmd(1'b0, 13'd5, 13'd0, 4'd0);
    chk("t1_arvalid", AR_VALID, 1);
    chk("t1_araddr", AR_ADDR, 5);
    chk("t1_busy", busy, 1);
    wait_done("t1");
    chk("t1_err", got_err, 0);
    chk("t1_busy_at_done", got_busy, 1);
    chk("t1_nbeats", beats.size() - nb, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t1_b%0d", k), beats[nb+k], exp1[k]);
    @(negedge clk);
    chk("t1_done_pulse", {done, err, busy}, 0);

    // T2: copy 100..103 -> 200..203 with random slave stalls.
    dly_en = 1'b1;
    nb = beats.size(); naw = aw_cnt; nw = w_cnt;
    cmd(1'b1, 13'd100, 13'd200, 4'd3);
    wait_done("t2");
    dly_en = 1'b0;
    chk("t2_err", got_err, 0);
    chk("t2_aw", aw_cnt - naw, 4);
    chk("t2_w", w_cnt - nw, 4);
    chk("t2_nbeats", beats.size() - nb, 32);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t2_mem%0d", j), wmem[200+j], memval(100 + j));
      chk_word($sformatf("t2_w%0d", j), nb + 8 * j, memval(100 + j));
    end
    chk("t2_no_overlap", ovl, 0);

    // T3: address wrap 8191 -> 0.
    nb = beats.size(); na = ar_log.size();
    cmd(1'b0, 13'd8191, 13'd0, 4'd1);
    wait_done("t3");
    chk("t3_nar", ar_log.size() - na, 2);
    chk("t3_ar0", ar_log[na], 8191);
    chk("t3_ar1", ar_log[na+1], 0);
    chk("t3_nbeats", beats.size() - nb, 16);
    chk_word("t3_w0", nb, memval(8191));
    chk_word("t3_w1", nb + 8, memval(0));

    // T4: SLVERR on the second word of a 4-word burst.
    err_addr = 32'd101;
    nb = beats.size(); na = ar_cnt;
    cmd(1'b0, 13'd100, 13'd0, 4'd3);
    wait_done("t4");
    chk("t4_err", got_err, 1);
    @(negedge clk);
    chk("t4_pulse", {done, err}, 0);
    repeat (10) @(negedge clk);
    chk("t4_nar", ar_cnt - na, 2);
    chk("t4_nbeats", beats.size() - nb, 8);
    chk_word("t4_w0", nb, memval(100));
    err_addr = 32'hFFFF_FFFF;

    // T5: reset while W_VALID is held, then a clean command.
    w_hold = 1'b1;
    cmd(1'b1, 13'd10, 13'd20, 4'd0);
    n = 0;
    while (W_VALID !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("t5_wvalid", W_VALID, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ctl", {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, busy, done, err, out_valid}, 0);
    chk("t5_rst_data", {W_DATA, out_data}, 0);
    chk("t5_rst_addr", {AR_ADDR, AW_ADDR}, 0);
    @(negedge clk);
    rst = 1'b0; w_hold = 1'b0;
    nb = beats.size();
    cmd(1'b0, 13'd5, 13'd0, 4'd0);
    wait_done("t5");
    chk("t5_err", got_err, 0);
    chk("t5_nbeats", beats.size() - nb, 8);
    chk_word("t5_w0", nb, memval(5));
    chk("t5_zero_idle", zviol, 0);

    // T6: 32/16 instance, 2 words, with a command pulse while busy.
    nb = beats2.size(); na = ar_cnt2;
    @(negedge clk);
    src2 = 13'd40; len2 = 4'd1; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("t6_busy", busy2, 1);
    @(negedge clk);
    src2 = 13'd300; len2 = 4'd0; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("t6_done", done2, 1);
    chk("t6_err", err2, 0);
    repeat (10) @(negedge clk);
    chk("t6_nar", ar_cnt2 - na, 2);
    chk("t6_idle", busy2, 0);
    chk("t6_nbeats", beats2.size() - nb, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t6_b%0d", k), beats2[nb+k], exp6[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
